// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI burst/response encodings, latched request and responder states
package axi_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam logic [1:0] RSVD   = 2'b11;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_req_t;

  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - next beat address for FIXED/INCR/WRAP bursts
// Shared with the cache refill path; purely combinational.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next_addr
);

  logic [1:0]  w_size;
  logic [31:0] w_incr;
  logic [31:0] w_mask;
  logic        w_wrap_ok;

  // Data path is 32 bits wide, so anything wider than a word steps by a word.
  assign w_size    = (i_size > 3'd2) ? 2'd2 : i_size[1:0];
  assign w_incr    = i_addr + (32'd1 << w_size);
  assign w_wrap_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
  assign w_mask    = (({24'd0, i_len} + 32'd1) << w_size) - 32'd1;

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      FIXED:   o_next_addr = i_addr;
      WRAP:    if (w_wrap_ok) o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default: o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI3 responder over a byte-enable word SRAM
// Reads and writes share one latched request; a round-robin bit arbitrates AR vs AW.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  ax_req_t           r_req;
  logic [7:0]        r_cnt;
  logic              r_sel_rd;
  logic              r_wover;
  logic [31:0]       r_rdata;
  logic [1:0]        r_bresp;

  logic [31:0]       w_next_addr;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_ar_hs;
  logic              w_aw_hs;
  logic              w_r_hs;
  logic              w_w_beat;
  logic              w_last_beat;
  logic              w_rsvd;
  logic              w_we;
  logic              w_unused;

  axi_burst_addr u_burst_addr (
    .i_addr      (r_req.addr),
    .i_len       (r_req.len),
    .i_size      (r_req.size),
    .i_burst     (r_req.burst),
    .o_next_addr (w_next_addr)
  );

  assign w_last_beat = (r_cnt == r_req.len);
  assign w_rsvd      = (r_req.burst == RSVD);
  assign w_ar_hs     = arvalid & arready;
  assign w_aw_hs     = awvalid & awready;
  assign w_r_hs      = rvalid & rready;
  assign w_w_beat    = wvalid & wready;
  // Beats past len (no wlast yet) are swallowed without touching memory.
  assign w_we        = w_w_beat & ~r_wover & ~w_rsvd;
  assign w_wr_idx    = r_req.addr[ADDR_W+1:2];
  assign w_rd_idx    = (r_state == IDLE) ? araddr[ADDR_W+1:2] : w_next_addr[ADDR_W+1:2];

  assign rid   = r_req.id;
  assign rdata = r_rdata;
  assign rresp = w_rsvd ? SLVERR : OKAY;
  assign rlast = rvalid & w_last_beat;
  assign bid   = r_req.id;
  assign bresp = r_bresp;

  assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  always_comb begin
    w_state_nxt = r_state;
    arready     = 1'b0;
    awready     = 1'b0;
    rvalid      = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (r_state)
      IDLE: begin
        arready = arvalid & (r_sel_rd | ~awvalid);
        awready = awvalid & (~r_sel_rd | ~arvalid);
        if (arready)      w_state_nxt = RD;
        else if (awready) w_state_nxt = WR;
      end
      RD: begin
        rvalid = 1'b1;
        if (rready && w_last_beat) w_state_nxt = IDLE;
      end
      WR: begin
        wready = 1'b1;
        if (wvalid && wlast) w_state_nxt = WB;
      end
      WB: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_cnt    <= '0;
      r_sel_rd <= 1'b1;
      r_wover  <= 1'b0;
      r_rdata  <= '0;
      r_bresp  <= OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (w_ar_hs || w_aw_hs) begin
        r_sel_rd <= ~r_sel_rd;
        r_cnt    <= '0;
        r_wover  <= 1'b0;
        if (w_ar_hs) r_req <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
        else         r_req <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
      end
      if (w_ar_hs) r_rdata <= (arburst == RSVD) ? '0 : r_mem[w_rd_idx];
      // Prefetch the next beat on each accepted beat so back-to-back beats run at 1/cycle.
      if (w_r_hs && !w_last_beat) begin
        r_cnt      <= r_cnt + 8'd1;
        r_req.addr <= w_next_addr;
        r_rdata    <= w_rsvd ? '0 : r_mem[w_rd_idx];
      end
      if (w_w_beat) begin
        r_req.addr <= w_next_addr;
        if (!r_wover) begin
          r_cnt <= r_cnt + 8'd1;
          if (w_last_beat && !wlast) r_wover <= 1'b1;
        end
        if (wlast) r_bresp <= (!w_last_beat || r_wover || w_rsvd) ? SLVERR : OKAY;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed self-checking bench for axi_sram_slave
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_data[$];
  logic [3:0]  wr_strb[$];
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  logic [31:0] rd_data[$];
  logic        rd_last[$];
  logic [1:0]  rd_resp[$];
  logic [3:0]  rd_id[$];
  int          rd_lat;
  int          rd_unstable;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.ADDR_W(14), .INIT_FILE("")) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000),
    .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic apply_reset();
    arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; rready = 0; bready = 0;
    aresetn = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input int last_at);
    int n;
    @(negedge aclk);
    awvalid = 1; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awid = id;
    #1; n = 0;
    while (!awready && n < 50) begin @(negedge aclk); #1; n++; end
    checks++;
    if (!awready) begin failures++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
    @(posedge aclk);
    for (int i = 0; i < wr_data.size(); i++) begin
      @(negedge aclk);
      awvalid = 0; wvalid = 1; wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == last_at);
      #1; n = 0;
      while (!wready && n < 50) begin @(negedge aclk); #1; n++; end
      @(posedge aclk);
    end
    @(negedge aclk);
    awvalid = 0; wvalid = 0; wlast = 0; bready = 1;
    #1; n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); #1; n++; end
    checks++;
    if (!bvalid) begin failures++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
    wr_resp = bresp; wr_bid = bid;
    @(posedge aclk);
    @(negedge aclk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input bit stall);
    int n;
    logic [31:0] hd;
    logic hl;
    rd_data.delete(); rd_last.delete(); rd_resp.delete(); rd_id.delete();
    rd_unstable = 0;
    @(negedge aclk);
    arvalid = 1; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arid = id;
    #1; n = 0;
    while (!arready && n < 50) begin @(negedge aclk); #1; n++; end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    rd_lat = n;
    n = 0;
    while (rd_data.size() < int'(len) + 1 && n < 2000) begin
      n++;
      if (stall && $urandom_range(0, 2) == 0) begin
        rready = 0; hd = rdata; hl = rlast;
        @(negedge aclk);
        if (!rvalid || rdata !== hd || rlast !== hl) rd_unstable++;
      end else if (rvalid) begin
        rready = 1;
        rd_data.push_back(rdata); rd_last.push_back(rlast);
        rd_resp.push_back(rresp); rd_id.push_back(rid);
        @(negedge aclk);
        rready = 0;
      end else begin
        @(negedge aclk);
      end
    end
    checks++;
    if (n >= 2000) begin failures++; $display("FAIL r_timeout: beats=%0d required %0d", rd_data.size(), int'(len) + 1); end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b0)
      begin failures++; $display("FAIL reset_ctrl: got %b required 000000", {arready, awready, rvalid, rlast, wready, bvalid}); end
    checks++;
    if (rdata !== 32'h0 || rid !== 4'h0 || rresp !== 2'b00)
      begin failures++; $display("FAIL reset_r: rdata=%h rid=%h rresp=%b required 0", rdata, rid, rresp); end
    checks++;
    if (bid !== 4'h0 || bresp !== 2'b00)
      begin failures++; $display("FAIL reset_b: bid=%h bresp=%b required 0", bid, bresp); end
  endtask

  task automatic test_single_read();
    wr_data = '{32'hDEADBEEF}; wr_strb = '{4'hF};
    axi_write(32'h400, 8'd0, INCR, 4'd1, 0);
    checks++;
    if (wr_resp !== OKAY || wr_bid !== 4'd1)
      begin failures++; $display("FAIL single_wr_b: bresp=%b bid=%h required 00/1", wr_resp, wr_bid); end
    axi_read(32'h400, 8'd0, INCR, 4'd3, 1'b0);
    checks++;
    if (rd_lat !== 0) begin failures++; $display("FAIL single_latency: extra cycles=%0d required 0", rd_lat); end
    checks++;
    if (rd_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata: got %h required deadbeef", rd_data[0]); end
    checks++;
    if (rd_id[0] !== 4'd3 || rd_last[0] !== 1'b1 || rd_resp[0] !== OKAY)
      begin failures++; $display("FAIL single_attr: rid=%h rlast=%b rresp=%b required 3/1/00", rd_id[0], rd_last[0], rd_resp[0]); end
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_drop: rvalid=%b required 0", rvalid); end
  endtask

  task automatic test_incr_write_read();
    logic [31:0] exp_d[4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    wr_data = '{32'd1, 32'd2, 32'd3, 32'd4}; wr_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(32'h1000, 8'd3, INCR, 4'd2, 3);
    checks++;
    if (wr_resp !== OKAY || wr_bid !== 4'd2)
      begin failures++; $display("FAIL incr_wr_b: bresp=%b bid=%h required 00/2", wr_resp, wr_bid); end
    axi_read(32'h1000, 8'd3, INCR, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3))
        begin failures++; $display("FAIL incr_beat%0d: data=%h last=%b required %h/%b", i, rd_data[i], rd_last[i], exp_d[i], i == 3); end
    end
    checks++;
    if (rd_unstable !== 0) begin failures++; $display("FAIL incr_stall_hold: changes=%0d required 0", rd_unstable); end
  endtask

  task automatic test_wrap_read();
    logic [31:0] exp_w[4] = '{32'd6, 32'd7, 32'd4, 32'd5};
    wr_data = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    wr_strb = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(32'h20, 8'd7, INCR, 4'd5, 7);
    axi_read(32'h38, 8'd3, WRAP, 4'd6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_w[i]) begin failures++; $display("FAIL wrap_beat%0d: got %h required %h", i, rd_data[i], exp_w[i]); end
    end
    axi_read(32'h24, 8'd2, FIXED, 4'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data[i] !== 32'd1) begin failures++; $display("FAIL fixed_beat%0d: got %h required 1", i, rd_data[i]); end
    end
    axi_read(32'h24, 8'd1, RSVD, 4'd6, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_data[i] !== 32'h0 || rd_resp[i] !== SLVERR)
        begin failures++; $display("FAIL rsvd_rd%0d: data=%h resp=%b required 0/10", i, rd_data[i], rd_resp[i]); end
    end
    wr_data = '{32'hFFFFFFFF}; wr_strb = '{4'hF};
    axi_write(32'h20, 8'd0, RSVD, 4'd7, 0);
    checks++;
    if (wr_resp !== SLVERR) begin failures++; $display("FAIL rsvd_wr_b: bresp=%b required 10", wr_resp); end
    axi_read(32'h20, 8'd0, INCR, 4'd7, 1'b0);
    checks++;
    if (rd_data[0] !== 32'h0) begin failures++; $display("FAIL rsvd_wr_suppress: got %h required 0", rd_data[0]); end
  endtask

  task automatic test_strobes();
    wr_data = '{32'h11111111}; wr_strb = '{4'hF};
    axi_write(32'h3000, 8'd0, INCR, 4'd1, 0);
    wr_data = '{32'hAABBCCDD}; wr_strb = '{4'h5};
    axi_write(32'h3000, 8'd0, INCR, 4'd1, 0);
    axi_read(32'h3000, 8'd0, INCR, 4'd1, 1'b0);
    checks++;
    if (rd_data[0] !== 32'h11BB11DD) begin failures++; $display("FAIL strobe_merge: got %h required 11bb11dd", rd_data[0]); end
  endtask

  task automatic test_overrun();
    logic [31:0] exp_o[3] = '{32'hA, 32'hB, 32'h55};
    wr_data = '{32'h55}; wr_strb = '{4'hF};
    axi_write(32'h4008, 8'd0, INCR, 4'd1, 0);
    wr_data = '{32'hA, 32'hB, 32'hC}; wr_strb = '{4'hF, 4'hF, 4'hF};
    axi_write(32'h4000, 8'd1, INCR, 4'd8, 2);
    checks++;
    if (wr_resp !== SLVERR || wr_bid !== 4'd8)
      begin failures++; $display("FAIL overrun_b: bresp=%b bid=%h required 10/8", wr_resp, wr_bid); end
    axi_read(32'h4000, 8'd2, INCR, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data[i] !== exp_o[i]) begin failures++; $display("FAIL overrun_mem%0d: got %h required %h", i, rd_data[i], exp_o[i]); end
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
    @(negedge aclk);
    arvalid = 1; araddr = 32'h400; arlen = 0; arsize = 3'd2; arburst = INCR; arid = 4'd5;
    awvalid = 1; awaddr = 32'h2000; awlen = 8'd3; awsize = 3'd2; awburst = INCR; awid = 4'd9;
    #1;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b0)
      begin failures++; $display("FAIL arb_first: arready=%b awready=%b required 1/0", arready, awready); end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0; rready = 1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rid !== 4'd5)
      begin failures++; $display("FAIL arb_read: rvalid=%b rdata=%h rid=%h required 1/deadbeef/5", rvalid, rdata, rid); end
    @(posedge aclk);
    @(negedge aclk);
    rready = 0; arvalid = 1; araddr = 32'h1004; arid = 4'd6;
    #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b0)
      begin failures++; $display("FAIL arb_second: arready=%b awready=%b required 0/1", arready, awready); end
    @(posedge aclk);
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      awvalid = 0; wvalid = 1; wdata = 32'hA0 + i; wstrb = 4'hF; wlast = (i == 1);
      @(posedge aclk);
    end
    @(negedge aclk);
    wvalid = 0; wlast = 0; bready = 1;
    #1;
    checks++;
    if (bvalid !== 1'b1 || bresp !== SLVERR || bid !== 4'd9)
      begin failures++; $display("FAIL early_wlast: bvalid=%b bresp=%b bid=%h required 1/10/9", bvalid, bresp, bid); end
    @(posedge aclk);
    @(negedge aclk);
    bready = 0;
    #1;
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL arb_no_starve: arready=%b required 1", arready); end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0; rready = 1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd2 || rid !== 4'd6 || rlast !== 1'b1)
      begin failures++; $display("FAIL arb_pending_read: rvalid=%b rdata=%h rid=%h rlast=%b required 1/2/6/1", rvalid, rdata, rid, rlast); end
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    @(negedge aclk);
    arvalid = 1; araddr = 32'h1000; arlen = 8'd3; arsize = 3'd2; arburst = INCR; arid = 4'd7;
    #1; n = 0;
    while (!arready && n < 50) begin @(negedge aclk); #1; n++; end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0; rready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd2)
      begin failures++; $display("FAIL midburst_beat1: rvalid=%b rdata=%h required 1/2", rvalid, rdata); end
    #1 aresetn = 0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || wready !== 1'b0 || bvalid !== 1'b0)
      begin failures++; $display("FAIL async_reset: rvalid=%b rlast=%b rdata=%h wready=%b bvalid=%b required 0", rvalid, rlast, rdata, wready, bvalid); end
    @(negedge aclk);
    aresetn = 1;
    axi_read(32'h400, 8'd0, INCR, 4'd1, 1'b0);
    checks++;
    if (rd_lat !== 0 || rd_data[0] !== 32'hDEADBEEF || rd_id[0] !== 4'd1)
      begin failures++; $display("FAIL post_reset_read: lat=%0d data=%h rid=%h required 0/deadbeef/1", rd_lat, rd_data[0], rd_id[0]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_incr_write_read();
    test_wrap_read();
    test_strobes();
    test_overrun();
    test_arbitration();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
